// File: rtl/btn_cond_pkg.sv
// Shared constants, debounce counter sizing and the debounce debug state for btn_conditioner.
package btn_cond_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } db_state_t;

  // Counter must hold DB_CYCLES-1; a width of at least 1 keeps DB_CYCLES = 1 legal.
  function automatic int db_cnt_w(input int db_cycles);
    return (db_cycles < 1) ? 1 : $clog2(db_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One-bit input conditioner: 2-flop synchroniser, stability counter, debounced level and edge pulses.
module debounce_cell
  import btn_cond_pkg::*;
#(
  parameter int DB_CYCLES = 250000
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      raw,
  output logic      level,
  output logic      rise,
  output logic      fall,
  output db_state_t state
);

  localparam int              CNT_W   = db_cnt_w(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s2;
  logic [CNT_W-1:0]       cnt;

  assign s2    = sync[SYNC_STAGES-1];
  assign state = (s2 != level) ? COUNTING : STABLE;

  // Any sample agreeing with the current level discards the partial count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= s2;
        rise  <= s2;
        fall  <= ~s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  a_rise_fall_excl: assert property (@(posedge clk) disable iff (!reset_n) !(rise && fall));

endmodule

// File: rtl/btn_conditioner.sv
// Pad front end: synchronises and debounces the buttons, conditions the switch bus.
// Define SW_DEBOUNCE_EN to debounce the switches as well; otherwise they are only synchronised.
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int N_BTN     = 2,
  parameter int SW_W      = 4,
  parameter int DB_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [SW_W-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall,
  output logic [SW_W-1:0]  sw_out
);

  db_state_t btn_state [N_BTN];

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (btn_raw[i]),
      .level   (btn_level[i]),
      .rise    (btn_rise[i]),
      .fall    (btn_fall[i]),
      .state   (btn_state[i])
    );

    a_rise_after_count: assert property (@(posedge clk) disable iff (!reset_n)
      btn_rise[i] |-> $past(btn_state[i]) == COUNTING);
  end

`ifdef SW_DEBOUNCE_EN
  logic [SW_W-1:0] sw_rise;
  logic [SW_W-1:0] sw_fall;
  db_state_t       sw_state [SW_W];

  // Switch edge pulses stay internal; they only feed the sanity checks below.
  for (genvar j = 0; j < SW_W; j++) begin : g_sw
    debounce_cell #(.DB_CYCLES(DB_CYCLES)) u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (sw_raw[j]),
      .level   (sw_out[j]),
      .rise    (sw_rise[j]),
      .fall    (sw_fall[j]),
      .state   (sw_state[j])
    );

    a_sw_edge_excl: assert property (@(posedge clk) disable iff (!reset_n)
      !(sw_rise[j] && sw_fall[j]));
    a_sw_change_after_count: assert property (@(posedge clk) disable iff (!reset_n)
      (sw_rise[j] || sw_fall[j]) |-> $past(sw_state[j]) == COUNTING);
  end
`else
  logic [SW_W-1:0] sw_sync [SYNC_STAGES];

  for (genvar k = 0; k < SYNC_STAGES; k++) begin : g_sw_sync
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sw_sync[k] <= '0;
      end else if (k == 0) begin
        sw_sync[k] <= sw_raw;
      end else begin
        sw_sync[k] <= sw_sync[(k == 0) ? 0 : k-1];
      end
    end
  end

  assign sw_out = sw_sync[SYNC_STAGES-1];
`endif

endmodule
